// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, scheduler states and default timing shared by the phase scheduler.
package traffic_pkg;
    typedef enum logic [1:0] {LT_RED = 2'd0, LT_YELLOW = 2'd1, LT_GREEN = 2'd2} light_t;
    typedef enum logic [1:0] {ST_ALLRED = 2'd0, ST_GREEN = 2'd1, ST_YELLOW = 2'd2} state_t;
    localparam int DEF_N    = 4;
    localparam int DEF_GMIN = 4;
    localparam int DEF_GMAX = 12;
    localparam int DEF_YDLY = 3;
    localparam int DEF_RDLY = 2;
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        return m > c ? m : c;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after last, with last searched at the end.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] winner,
    output logic                 valid
);
    localparam int W = $clog2(N);
    logic [W-1:0] idx;
    // Walk offsets from farthest to nearest so the nearest set request is written last.
    always_comb begin
        winner = last;
        valid  = 1'b0;
        idx    = '0;
        for (int k = N; k >= 1; k--) begin
            idx = W'((int'(last) + k) % N);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/phase_scheduler.sv
// phase_scheduler: N-way actuated traffic phase controller with min/max green, yellow and all-red clearance.
module phase_scheduler
    import traffic_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int GMIN = DEF_GMIN,
    parameter int GMAX = DEF_GMAX,
    parameter int YDLY = DEF_YDLY,
    parameter int RDLY = DEF_RDLY
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [N-1:0]         req,
    output logic [2*N-1:0]       lights,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 green_start
);
    localparam int W    = $clog2(N);
    localparam int TMAX = max3(GMAX, YDLY, RDLY);
    localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] R_END    = TW'(RDLY - 1);
    localparam logic [TW-1:0] GMIN_END = TW'(GMIN - 1);
    localparam logic [TW-1:0] GMAX_END = TW'(GMAX - 1);
    localparam logic [TW-1:0] Y_END    = TW'(YDLY - 1);
    state_t        state;
    logic [TW-1:0] t;
    logic [W-1:0]  cur;
    logic [W-1:0]  winner;
    logic          valid;
    logic          other;
    rr_arbiter #(.N(N)) u_arb (
        .req    (req),
        .last   (cur),
        .winner (winner),
        .valid  (valid)
    );
    assign other = |(req & ~(N'(1) << cur));
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= ST_ALLRED;
            t     <= '0;
            cur   <= W'(N - 1);
        end else begin
            case (state)
                ST_ALLRED: begin
                    if (t >= R_END && valid) begin
                        state <= ST_GREEN;
                        t     <= '0;
                        cur   <= winner;
                    end else if (t < R_END) begin
                        t <= t + 1'b1;
                    end
                end
                ST_GREEN: begin
                    // An uncontested green rests even after its own request drops.
                    if (other && ((t >= GMIN_END && !req[cur]) || t == GMAX_END)) begin
                        state <= ST_YELLOW;
                        t     <= '0;
                    end else if (t < GMAX_END) begin
                        t <= t + 1'b1;
                    end
                end
                ST_YELLOW: begin
                    state <= t == Y_END ? ST_ALLRED : ST_YELLOW;
                    t     <= t == Y_END ? '0 : t + 1'b1;
                end
                default: begin
                    state <= ST_ALLRED;
                    t     <= '0;
                end
            endcase
        end
    end
    always_comb begin
        lights = '0;
        for (int i = 0; i < N; i++)
            lights[2*i +: 2] = (state != ST_ALLRED && cur == W'(i)) ?
                               (state == ST_GREEN ? LT_GREEN : LT_YELLOW) : LT_RED;
    end
    assign grant_idx   = cur;
    assign green_start = state == ST_GREEN && t == '0;
endmodule

// File: tb/tb_phase_scheduler.sv
// tb_phase_scheduler: directed scenario tests for the 4-way phase scheduler with default timing.
module tb_phase_scheduler;
    logic       clock = 1'b0;
    logic       clear;
    logic [3:0] req;
    logic [7:0] lights;
    logic [1:0] grant_idx;
    logic       green_start;
    int checks = 0;
    int errors = 0;
    int unsafe = 0;

    phase_scheduler dut (
        .clock       (clock),
        .clear       (clear),
        .req         (req),
        .lights      (lights),
        .grant_idx   (grant_idx),
        .green_start (green_start)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        if (($countones({|lights[7:6], |lights[5:4], |lights[3:2], |lights[1:0]})) > 1) unsafe++;
    endtask

    task automatic restart(input logic [3:0] r);
        @(negedge clock);
        clear = 1'b1;
        req   = r;
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic measure(input logic [7:0] pat, output int n);
        n = 0;
        while (lights === pat && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        int bad;
        @(negedge clock);
        clear = 1'b1;
        req   = 4'b0000;
        @(negedge clock);
        checks++; if (lights !== 8'h00) begin errors++; $display("FAIL reset_lights got %h exp 00", lights); end
        checks++; if (grant_idx !== 2'd3) begin errors++; $display("FAIL reset_grant got %0d exp 3", grant_idx); end
        checks++; if (green_start !== 1'b0) begin errors++; $display("FAIL reset_gs got %b exp 0", green_start); end
        clear = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (lights !== 8'h00 || green_start !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_red bad_cycles %0d exp 0", bad); end
    endtask

    task automatic test_first_green();
        int bad;
        restart(4'b0001);
        checks++; if (lights !== 8'h00) begin errors++; $display("FAIL first_red0 got %h exp 00", lights); end
        tick();
        checks++; if (lights !== 8'h00) begin errors++; $display("FAIL first_red1 got %h exp 00", lights); end
        tick();
        checks++; if (lights !== 8'h02) begin errors++; $display("FAIL first_green got %h exp 02", lights); end
        checks++; if (green_start !== 1'b1) begin errors++; $display("FAIL first_gs got %b exp 1", green_start); end
        checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL first_grant got %0d exp 0", grant_idx); end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (lights !== 8'h02 || green_start !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL green_rest bad_cycles %0d exp 0", bad); end
    endtask

    task automatic test_max_green();
        int n;
        restart(4'b0001);
        tick();
        tick();
        req = 4'b0101;
        measure(8'h02, n);
        checks++; if (n !== 12) begin errors++; $display("FAIL max_green_len got %0d exp 12", n); end
        measure(8'h01, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL max_yellow_len got %0d exp 3", n); end
        measure(8'h00, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL max_allred_len got %0d exp 2", n); end
        checks++; if (lights !== 8'h20) begin errors++; $display("FAIL max_next_green got %h exp 20", lights); end
        checks++; if (grant_idx !== 2'd2) begin errors++; $display("FAIL max_next_grant got %0d exp 2", grant_idx); end
        checks++; if (green_start !== 1'b1) begin errors++; $display("FAIL max_next_gs got %b exp 1", green_start); end
    endtask

    task automatic test_gap_out();
        int n;
        restart(4'b0001);
        tick();
        tick();
        tick();
        req = 4'b0010;
        measure(8'h02, n);
        checks++; if (n + 1 !== 4) begin errors++; $display("FAIL gap_green_len got %0d exp 4", n + 1); end
        measure(8'h01, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL gap_yellow_len got %0d exp 3", n); end
        measure(8'h00, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL gap_allred_len got %0d exp 2", n); end
        checks++; if (lights !== 8'h08) begin errors++; $display("FAIL gap_next_green got %h exp 08", lights); end
        checks++; if (grant_idx !== 2'd1) begin errors++; $display("FAIL gap_next_grant got %0d exp 1", grant_idx); end
    endtask

    task automatic test_round_robin();
        int n;
        int exp_idx;
        logic [7:0] gpat;
        logic [7:0] ypat;
        restart(4'b1111);
        unsafe = 0;
        measure(8'h00, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL rr_initial_red got %0d exp 2", n); end
        for (int k = 0; k < 5; k++) begin
            exp_idx = k % 4;
            gpat = 8'h02 << (2 * exp_idx);
            ypat = 8'h01 << (2 * exp_idx);
            checks++; if (grant_idx !== 2'(exp_idx)) begin errors++; $display("FAIL rr_grant%0d got %0d exp %0d", k, grant_idx, exp_idx); end
            checks++; if (green_start !== 1'b1) begin errors++; $display("FAIL rr_gs%0d got %b exp 1", k, green_start); end
            measure(gpat, n);
            checks++; if (n !== 12) begin errors++; $display("FAIL rr_green%0d got %0d exp 12", k, n); end
            if (k < 4) begin
                measure(ypat, n);
                checks++; if (n !== 3) begin errors++; $display("FAIL rr_yellow%0d got %0d exp 3", k, n); end
                measure(8'h00, n);
                checks++; if (n !== 2) begin errors++; $display("FAIL rr_red%0d got %0d exp 2", k, n); end
            end
        end
        checks++; if (unsafe !== 0) begin errors++; $display("FAIL rr_safety unsafe_cycles %0d exp 0", unsafe); end
    endtask

    task automatic test_clear_mid_yellow();
        int n;
        restart(4'b0010);
        tick();
        tick();
        checks++; if (lights !== 8'h08) begin errors++; $display("FAIL clr_green1 got %h exp 08", lights); end
        req = 4'b1101;
        n = 0;
        while (lights !== 8'h04 && n < 50) begin
            n++;
            tick();
        end
        checks++; if (lights !== 8'h04) begin errors++; $display("FAIL clr_yellow1 got %h exp 04", lights); end
        req = 4'b1111;
        tick();
        #1 clear = 1'b1;
        #1;
        checks++; if (lights !== 8'h00) begin errors++; $display("FAIL clr_async_red got %h exp 00", lights); end
        checks++; if (grant_idx !== 2'd3) begin errors++; $display("FAIL clr_async_grant got %0d exp 3", grant_idx); end
        @(negedge clock);
        clear = 1'b0;
        measure(8'h00, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL clr_allred_len got %0d exp 2", n); end
        checks++; if (lights !== 8'h02) begin errors++; $display("FAIL clr_first_green got %h exp 02", lights); end
        checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL clr_first_grant got %0d exp 0", grant_idx); end
    endtask

    initial begin
        clear = 1'b0;
        req   = 4'b0000;
        #2 clear = 1'b1;
        test_reset();
        test_first_green();
        test_max_green();
        test_gap_out();
        test_round_robin();
        test_clear_mid_yellow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
